// File: rtl/param_rx.sv
// Parameterised frame receiver. It checks the preamble, SFD, type, size and FCS of each frame,
// buffers the payload tentatively, and streams only committed frames out on an AXI-Stream port.
module param_rx #(
  parameter int          G_MEM_SIZE     = 512,
  parameter int          G_PREAMBLE_LEN = 3,
  parameter logic [7:0]  G_SFD          = 8'h7F,
  parameter logic [15:0] G_TYPE         = 16'h1234,
  parameter int          G_MIN_SIZE     = 8,
  parameter int          G_MAX_SIZE     = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rxd_in,
  input  logic        rxdv_in,
  input  logic        rxer_in,
  output logic [7:0]  tdata_out,
  output logic        tvalid_out,
  output logic        tlast_out,
  input  logic        tready_in,
  output logic [15:0] stat_packet_vld_cnt,
  output logic [15:0] stat_packet_err_cnt,
  output logic [15:0] stat_packet_drop_cnt
);

  localparam int         AW     = $clog2(G_MEM_SIZE);
  localparam logic [7:0] MIN_B  = 8'(G_MIN_SIZE);
  localparam logic [7:0] MAX_B  = 8'(G_MAX_SIZE);
  localparam logic [7:0] PRE_B  = 8'(G_PREAMBLE_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_TYPE, S_SIZE, S_PAYLOAD, S_FCS, S_END, S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  size_q, size_d;
  logic [7:0]  fcs_q, fcs_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cm_ptr_q, cm_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] vld_cnt_q, vld_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;

  logic [8:0]    mem_q [G_MEM_SIZE];
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [8:0]    wdata_s;
  logic          frame_err_s;
  logic          drop_s;
  logic          vld_s;
  logic          last_s;
  logic [AW:0]   used_s;
  logic [31:0]   free_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Free space counts only committed-unread bytes; the tentative frame is not yet owned.
  assign used_s = cm_ptr_q - rd_ptr_q;
  assign free_s = 32'(G_MEM_SIZE) - 32'(used_s);

  // Frame parser: next state, tentative write, and per-frame outcome.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    fcs_d       = fcs_q;
    wr_ptr_d    = wr_ptr_q;
    cm_ptr_d    = cm_ptr_q;
    frame_err_s = 1'b0;
    drop_s      = 1'b0;
    vld_s       = 1'b0;
    we_s        = 1'b0;
    waddr_s     = wr_ptr_q[AW-1:0];
    last_s      = (cnt_q == size_q - 8'd1);
    wdata_s     = {last_s, rxd_in};
    case (state_q)
      S_IDLE: begin
        cnt_d    = 8'd0;
        fcs_d    = 8'd0;
        wr_ptr_d = cm_ptr_q;
        if (rxdv_in) begin
          if (rxer_in || rxd_in != 8'h55) begin
            frame_err_s = 1'b1;
          end else begin
            state_d = S_PREAMBLE;
            cnt_d   = 8'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREAMBLE, S_TYPE, S_SIZE, S_PAYLOAD, S_FCS: begin
        if (!rxdv_in || rxer_in) begin
          frame_err_s = 1'b1;
        end else begin
          case (state_q)
            S_PREAMBLE: begin
              if (cnt_q < PRE_B) begin
                if (rxd_in == 8'h55) cnt_d = cnt_q + 8'd1;
                else frame_err_s = 1'b1;
              end else if (rxd_in == G_SFD) begin
                state_d = S_TYPE;
                cnt_d   = 8'd0;
              end else begin
                frame_err_s = 1'b1;
              end
            end
            S_TYPE: begin
              if (rxd_in == ((cnt_q == 8'd0) ? G_TYPE[15:8] : G_TYPE[7:0])) begin
                fcs_d = fcs_q + rxd_in;
                if (cnt_q == 8'd0) begin
                  cnt_d = 8'd1;
                end else begin
                  state_d = S_SIZE;
                  cnt_d   = 8'd0;
                end
              end else begin
                frame_err_s = 1'b1;
              end
            end
            S_SIZE: begin
              if (rxd_in < MIN_B || rxd_in > MAX_B) begin
                frame_err_s = 1'b1;
              end else if (32'(rxd_in) > free_s) begin
                drop_s = 1'b1;
              end else begin
                size_d  = rxd_in;
                fcs_d   = fcs_q + rxd_in;
                cnt_d   = 8'd0;
                state_d = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              we_s     = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              fcs_d    = fcs_q + rxd_in;
              cnt_d    = cnt_q + 8'd1;
              if (last_s) state_d = S_FCS;
              else state_d = S_PAYLOAD;
            end
            S_FCS: begin
              if (rxd_in == fcs_q) state_d = S_END;
              else frame_err_s = 1'b1;
            end
            default: frame_err_s = 1'b1;
          endcase
        end
      end
      S_END: begin
        if (rxdv_in) begin
          frame_err_s = 1'b1;
        end else begin
          cm_ptr_d = wr_ptr_q;
          vld_s    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DROP: begin
        wr_ptr_d = cm_ptr_q;
        if (!rxdv_in) state_d = S_IDLE;
        else state_d = S_DROP;
      end
      default: begin
        state_d  = S_IDLE;
        wr_ptr_d = cm_ptr_q;
      end
    endcase
    // A failing frame still holding rxdv must be flushed through DROP; a truncated one is already over.
    if (frame_err_s || drop_s) begin
      wr_ptr_d = cm_ptr_q;
      state_d  = (rxdv_in) ? S_DROP : S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Output stage: refill the registered beat whenever it is empty or being accepted.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (!tvalid_q || tready_in) begin
      if (rd_ptr_q != cm_ptr_q) begin
        {tlast_d, tdata_d} = mem_q[rd_ptr_q[AW-1:0]];
        tvalid_d           = 1'b1;
        rd_ptr_d           = rd_ptr_q + 1'b1;
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Frame statistics, saturating.
  always_comb begin
    vld_cnt_d  = (vld_s)       ? sat_inc(vld_cnt_q)  : vld_cnt_q;
    err_cnt_d  = (frame_err_s) ? sat_inc(err_cnt_q)  : err_cnt_q;
    drop_cnt_d = (drop_s)      ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      size_q     <= 8'd0;
      fcs_q      <= 8'd0;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_cnt_q  <= 16'd0;
      err_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
      tdata_q    <= 8'd0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      fcs_q      <= fcs_d;
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_cnt_q  <= vld_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  // Payload buffer write port; entries carry the tlast flag in bit 8.
  always_ff @(posedge clk_in) begin
    if (we_s && !rst_in) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  assign tdata_out            = tdata_q;
  assign tvalid_out           = tvalid_q;
  assign tlast_out            = tlast_q;
  assign stat_packet_vld_cnt  = vld_cnt_q;
  assign stat_packet_err_cnt  = err_cnt_q;
  assign stat_packet_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_param_rx.sv
// Directed bench for param_rx: a frame-level model predicts each frame's outcome and output bytes,
// and a per-cycle compare process checks the AXI-Stream side against the expected byte queue.
module tb_param_rx;

  localparam int         P    = 3;
  localparam int         MEM  = 16;
  localparam int         MINS = 8;
  localparam int         MAXS = 15;
  localparam logic [7:0] SFD  = 8'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxer;
  logic        tready;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic [15:0] vld_cnt, err_cnt, drop_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  fb[$];
  int          exp_vld = 0, exp_err = 0, exp_drop = 0;
  int          tready_mode = 1;
  int          last_seen = 0;
  int          last_mark;

  param_rx #(
    .G_MEM_SIZE(MEM), .G_PREAMBLE_LEN(P), .G_SFD(SFD), .G_TYPE(16'h1234),
    .G_MIN_SIZE(MINS), .G_MAX_SIZE(MAXS)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rxd_in(rxd), .rxdv_in(rxdv), .rxer_in(rxer),
    .tdata_out(tdata), .tvalid_out(tvalid), .tlast_out(tlast), .tready_in(tready),
    .stat_packet_vld_cnt(vld_cnt), .stat_packet_err_cnt(err_cnt),
    .stat_packet_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame outcome from the layout rules: 0 = good, 1 = error, 2 = dropped for lack of space.
  function automatic int classify(input int rxer_from);
    int fcs_idx = 1 << 30;
    int n;
    int sum = 0;
    for (int i = 0; i < fb.size(); i++) begin
      if (rxer_from >= 0 && i >= rxer_from && i <= fcs_idx) return 1;
      if (i < P) begin
        if (fb[i] != 8'h55) return 1;
      end else if (i == P) begin
        if (fb[i] != SFD) return 1;
      end else if (i == P + 1) begin
        if (fb[i] != 8'h12) return 1;
        sum += int'(fb[i]);
      end else if (i == P + 2) begin
        if (fb[i] != 8'h34) return 1;
        sum += int'(fb[i]);
      end else if (i == P + 3) begin
        n = int'(fb[i]);
        if (n < MINS || n > MAXS) return 1;
        if (n > MEM - exp_q.size()) return 2;
        fcs_idx = P + 4 + n;
        sum += n;
      end else if (i < fcs_idx) begin
        sum += int'(fb[i]);
      end else if (i == fcs_idx) begin
        if (fb[i] != 8'(sum)) return 1;
      end else begin
        return 1;
      end
    end
    if (fb.size() <= fcs_idx) return 1;
    return 0;
  endfunction

  task automatic build(input logic [7:0] n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] b;
    logic [7:0] s;
    fb.delete();
    for (int k = 0; k < P; k++) fb.push_back(8'h55);
    fb.push_back(SFD);
    fb.push_back(8'h12);
    fb.push_back(8'h34);
    fb.push_back(n);
    s = 8'h12 + 8'h34 + n;
    b = first;
    for (int k = 0; k < int'(n); k++) begin
      fb.push_back(b);
      s = s + b;
      b = b + step;
    end
    fb.push_back(s);
  endtask

  task automatic chk_counters(input string tag);
    check({tag, "_vld"}, 32'(vld_cnt), 32'(exp_vld));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic send(input int rxer_from);
    int res;
    int n;
    res = classify(rxer_from);
    for (int i = 0; i < fb.size(); i++) begin
      rxd  = fb[i];
      rxdv = 1'b1;
      rxer = (rxer_from >= 0 && i >= rxer_from);
      @(posedge clk); #1;
    end
    rxdv = 1'b0;
    rxer = 1'b0;
    rxd  = 8'h00;
    @(posedge clk); #1;
    case (res)
      0: begin
        exp_vld++;
        n = int'(fb[P + 3]);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), fb[P + 4 + k]});
      end
      1: exp_err++;
      2: exp_drop++;
      default: exp_err = exp_err;
    endcase
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 300 && (exp_q.size() != 0 || tvalid); c++) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(tvalid), 32'd0);
  endtask

  // tready pattern generator.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tready_mode)
        0: tready = 1'b0;
        1: tready = 1'b1;
        default: tready = ~tready;
      endcase
    end
  end

  // Per-cycle output checker: ordered bytes, tlast placement, stability under back-pressure.
  initial begin
    logic       stall_prev;
    logic [8:0] prev;
    logic [8:0] e;
    stall_prev = 1'b0;
    prev       = 9'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_hold", 32'({tvalid, tlast, tdata}), 32'({1'b1, prev}));
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(tvalid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", 32'({tlast, tdata}), 32'(e));
            if (tlast) last_seen++;
          end
        end
        stall_prev = tvalid && !tready;
        prev       = {tlast, tdata};
      end
    end
  end

  initial begin
    rst  = 1'b1;
    rxd  = 8'h00;
    rxdv = 1'b0;
    rxer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    chk_counters("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Good frame, full-rate sink.
    build(8'd10, 8'h11, 8'h11);
    check("fcs_model", 32'(fb[fb.size() - 1]), 32'hF7);
    check("good_class", 32'(classify(-1)), 32'd0);
    last_mark = last_seen;
    send(-1);
    @(posedge clk); @(posedge clk); #1;
    check("latency", 32'(tvalid), 32'd1);
    wait_drain("good_drain");
    check("good_vld_lit", 32'(vld_cnt), 32'd1);
    check("good_tlast", 32'(last_seen - last_mark), 32'd1);
    chk_counters("good");

    // Bad preamble, bad type, undersize, bad FCS.
    build(8'd10, 8'h11, 8'h11); fb[0] = 8'h22; fb[1] = 8'h44; send(-1);
    build(8'd10, 8'h11, 8'h11); fb[P + 1] = 8'hAA; send(-1);
    build(8'd10, 8'h11, 8'h11); fb[P + 3] = 8'h03; send(-1);
    build(8'd10, 8'h11, 8'h11); fb[fb.size() - 1] = fb[fb.size() - 1] + 8'hFF; send(-1);
    wait_drain("err_drain");
    check("err_lit", 32'(err_cnt), 32'd4);
    check("err_vld_lit", 32'(vld_cnt), 32'd1);
    chk_counters("err");

    // PHY error from the size byte, then a clean frame.
    build(8'd10, 8'h11, 8'h11); send(P + 3);
    chk_counters("rxer");
    build(8'd9, 8'h01, 8'h03); send(-1);
    wait_drain("rxer_drain");
    chk_counters("after_rxer");

    // Buffer full: second frame is dropped while the sink stalls.
    tready_mode = 0;
    @(posedge clk); #1;
    build(8'd10, 8'h40, 8'h01); send(-1);
    build(8'd10, 8'h80, 8'h01); send(-1);
    repeat (4) @(posedge clk);
    #1;
    check("full_drop_lit", 32'(drop_cnt), 32'd1);
    check("full_hold", 32'(tvalid), 32'd1);
    chk_counters("full");
    tready_mode = 1;
    wait_drain("full_drain");

    // Toggling ready across three frames that wrap the buffer.
    tready_mode = 2;
    last_mark   = last_seen;
    for (int f = 0; f < 3; f++) begin
      build(8'd10, 8'(8'hA0 + 8'(f * 16)), 8'h05);
      send(-1);
      repeat (14) @(posedge clk);
      #1;
    end
    wait_drain("wrap_drain");
    check("wrap_tlast", 32'(last_seen - last_mark), 32'd3);
    chk_counters("wrap");
    tready_mode = 1;

    // Reset during payload discards everything.
    build(8'd10, 8'h11, 8'h11);
    for (int i = 0; i < P + 7; i++) begin
      rxd  = fb[i];
      rxdv = 1'b1;
      @(posedge clk); #1;
    end
    rst  = 1'b1;
    rxdv = 1'b0;
    exp_q.delete();
    exp_vld  = 0;
    exp_err  = 0;
    exp_drop = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_vld", 32'(vld_cnt), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_tvalid", 32'(tvalid), 32'd0);

    // Truncated after the fifth payload byte.
    build(8'd10, 8'h11, 8'h11);
    while (fb.size() > P + 9) void'(fb.pop_back());
    send(-1);
    repeat (4) @(posedge clk);
    #1;
    check("trunc_err_lit", 32'(err_cnt), 32'd1);
    check("trunc_tvalid", 32'(tvalid), 32'd0);
    chk_counters("trunc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
